// File: rtl/cpu_pkg.sv
// Shared sequencer definitions: FSM states, INT instruction op codes and
// default interrupt vector layout (also used by instruction_decode).
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_MEM_WAIT  = 3'd1,
        ST_INT_ENTRY = 3'd2,
        ST_HALTED    = 3'd3,
        ST_SOFT_RST  = 3'd4
    } seq_state_e;

    localparam logic [1:0] INT_DISABLE = 2'b00;
    localparam logic [1:0] INT_ENABLE  = 2'b01;
    localparam logic [1:0] INT_TRIGGER = 2'b10;
    localparam logic [1:0] INT_NOP     = 2'b11;

    localparam logic [15:0] VECTOR_BASE_DEF   = 16'h0010;
    localparam logic [15:0] VECTOR_STRIDE_DEF = 16'h0004;

    // Vector address wraps modulo 2^16 like the PC itself.
    function automatic logic [15:0] vector_addr(input logic [15:0] base,
                                                input logic [15:0] stride,
                                                input logic [15:0] idx);
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: reports the index of the lowest set
// request bit and whether any bit is set.
module irq_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        // Scan downwards so the lowest set index is the last one written.
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                idx_o   = IDX_W'(k);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Core control FSM: retire enable, LOAD/STOR memory handshake, interrupt
// entry/return PC overrides, HALT and the timed soft reset pulse.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int          NUM_IRQ       = 4,
    parameter logic [15:0] VECTOR_BASE   = VECTOR_BASE_DEF,
    parameter logic [15:0] VECTOR_STRIDE = VECTOR_STRIDE_DEF,
    parameter int          RESET_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        pc,
    input  logic               halt_cmd,
    input  logic               rst_cmd,
    input  logic               return_cmd,
    input  logic               int_valid,
    input  logic [1:0]         int_op,
    input  logic               mem_op,
    input  logic               mem_ack,
    input  logic [NUM_IRQ-1:0] ext_irq,
    output logic               clk_en,
    output logic               mem_req,
    output logic               pc_load,
    output logic [15:0]        pc_load_value,
    output logic               core_reset,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               int_enabled,
    output logic               in_isr,
    output logic               halted
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int CNT_W = $clog2(RESET_CYCLES + 1);

    seq_state_e         state_q, state_d;
    logic               int_en_q, int_en_d;
    logic               in_isr_q, in_isr_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [15:0]        epc_q, epc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               take_irq;
    logic               sw_trig;
    logic               clr_irq_state;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_valid;
    logic [15:0]        vector;

    irq_prio_enc #(
        .N     (NUM_IRQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .req_i   (pending_q),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    assign take_irq = int_en_q & ~in_isr_q & (|pending_q);
    assign vector   = vector_addr(VECTOR_BASE, VECTOR_STRIDE, 16'(enc_idx));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            int_en_q  <= 1'b0;
            in_isr_q  <= 1'b0;
            pending_q <= '0;
            epc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            int_en_q  <= int_en_d;
            in_isr_q  <= in_isr_d;
            pending_q <= pending_d;
            epc_q     <= epc_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        int_en_d      = int_en_q;
        in_isr_d      = in_isr_q;
        epc_d         = epc_q;
        cnt_d         = cnt_q;
        sw_trig       = 1'b0;
        clr_irq_state = 1'b0;
        clk_en        = 1'b0;
        mem_req       = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = '0;
        irq_ack       = '0;

        unique case (state_q)
            ST_RUN: begin
                // The instruction under a taken interrupt is not retired;
                // epc points back at it so RETURN re-executes it.
                if (take_irq) begin
                    epc_d   = pc;
                    state_d = ST_INT_ENTRY;
                end else if (rst_cmd) begin
                    cnt_d   = CNT_W'(RESET_CYCLES);
                    state_d = ST_SOFT_RST;
                end else if (halt_cmd) begin
                    state_d = ST_HALTED;
                end else if (return_cmd) begin
                    pc_load       = 1'b1;
                    pc_load_value = epc_q;
                    in_isr_d      = 1'b0;
                    int_en_d      = 1'b1;
                end else if (mem_op) begin
                    mem_req = 1'b1;
                    clk_en  = mem_ack;
                    if (!mem_ack) begin
                        state_d = ST_MEM_WAIT;
                    end
                end else begin
                    clk_en = 1'b1;
                    if (int_valid) begin
                        case (int_op)
                            INT_DISABLE: int_en_d = 1'b0;
                            INT_ENABLE:  int_en_d = 1'b1;
                            INT_TRIGGER: sw_trig  = 1'b1;
                            default:     ;
                        endcase
                    end
                end
            end
            ST_MEM_WAIT: begin
                mem_req = 1'b1;
                clk_en  = mem_ack;
                if (mem_ack) begin
                    state_d = ST_RUN;
                end
            end
            ST_INT_ENTRY: begin
                pc_load       = enc_valid;
                pc_load_value = vector;
                irq_ack       = enc_valid ? (NUM_IRQ'(1) << enc_idx) : '0;
                in_isr_d      = 1'b1;
                int_en_d      = 1'b0;
                state_d       = ST_RUN;
            end
            ST_HALTED: begin
                // HALT was never retired, so the resume point is past it.
                if (take_irq) begin
                    epc_d   = pc + 16'd2;
                    state_d = ST_INT_ENTRY;
                end else if (int_valid && (int_op == INT_TRIGGER)) begin
                    sw_trig = 1'b1;
                end
            end
            ST_SOFT_RST: begin
                clr_irq_state = 1'b1;
                int_en_d      = 1'b0;
                in_isr_d      = 1'b0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        pending_d = clr_irq_state ? '0
                  : ((pending_q | ext_irq | NUM_IRQ'(sw_trig)) & ~irq_ack);

        if (reset) begin
            clk_en        = 1'b0;
            mem_req       = 1'b0;
            pc_load       = 1'b0;
            pc_load_value = '0;
            irq_ack       = '0;
        end
    end

    assign core_reset  = (state_q == ST_SOFT_RST) && (cnt_q != '0);
    assign int_enabled = int_en_q;
    assign in_isr      = in_isr_q;
    assign halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_cpu_sequencer;

    localparam int M_RUN = 0, M_MEMW = 1, M_ENTRY = 2, M_HALT = 3, M_SRST = 4;

    typedef struct packed {
        logic        clk_en;
        logic        mem_req;
        logic        pc_load;
        logic [15:0] plv;
        logic [3:0]  ack;
    } comb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] pc_in, pc_env, pc_ovr_val;
    logic        pc_ovr;
    logic        halt_cmd, rst_cmd, return_cmd, int_valid, mem_op, mem_ack;
    logic [1:0]  int_op;
    logic [3:0]  ext_irq;
    logic        clk_en, mem_req, pc_load, core_reset, int_enabled, in_isr, halted;
    logic [15:0] pc_load_value;
    logic [3:0]  irq_ack;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    int          m_mode;
    bit          m_int_en, m_in_isr;
    logic [3:0]  m_pend;
    logic [15:0] m_epc;
    int          m_rst_left;

    assign pc_in = pc_ovr ? pc_ovr_val : pc_env;

    cpu_sequencer dut (
        .clk(clk), .reset(reset), .pc(pc_in),
        .halt_cmd(halt_cmd), .rst_cmd(rst_cmd), .return_cmd(return_cmd),
        .int_valid(int_valid), .int_op(int_op), .mem_op(mem_op), .mem_ack(mem_ack),
        .ext_irq(ext_irq), .clk_en(clk_en), .mem_req(mem_req), .pc_load(pc_load),
        .pc_load_value(pc_load_value), .core_reset(core_reset), .irq_ack(irq_ack),
        .int_enabled(int_enabled), .in_isr(in_isr), .halted(halted)
    );

    function automatic int first_pend(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return i;
        return -1;
    endfunction

    // Outputs that depend on the current inputs, derived from the rules.
    function automatic comb_t model_comb();
        comb_t r;
        int i;
        bit take;
        r = '0;
        if (reset) return r;
        take = m_int_en && !m_in_isr && (m_pend != 4'h0);
        if (m_mode == M_RUN) begin
            if (!(take || rst_cmd || halt_cmd)) begin
                if (return_cmd) begin
                    r.pc_load = 1'b1;
                    r.plv     = m_epc;
                end else if (mem_op) begin
                    r.mem_req = 1'b1;
                    r.clk_en  = mem_ack;
                end else begin
                    r.clk_en = 1'b1;
                end
            end
        end else if (m_mode == M_MEMW) begin
            r.mem_req = 1'b1;
            r.clk_en  = mem_ack;
        end else if (m_mode == M_ENTRY) begin
            i = first_pend(m_pend);
            if (i >= 0) begin
                r.pc_load = 1'b1;
                r.plv     = 16'((32'h10 + 32'h4 * i) % 65536);
                r.ack     = 4'(1 << i);
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin : model_upd
        comb_t       c;
        bit          take, sw;
        int          n_mode, n_left;
        bit          n_ie, n_isr;
        logic [3:0]  n_pend;
        logic [15:0] n_epc;
        c = model_comb();
        if (reset) begin
            m_mode <= M_RUN; m_int_en <= 1'b0; m_in_isr <= 1'b0;
            m_pend <= 4'h0;  m_epc <= 16'h0;    m_rst_left <= 0;
            pc_env <= 16'h0;
        end else begin
            n_mode = m_mode; n_ie = m_int_en; n_isr = m_in_isr;
            n_epc = m_epc;   n_left = m_rst_left; sw = 1'b0;
            take = m_int_en && !m_in_isr && (m_pend != 4'h0);
            case (m_mode)
                M_RUN: begin
                    if (take) begin n_epc = pc_in; n_mode = M_ENTRY; end
                    else if (rst_cmd) begin n_mode = M_SRST; n_left = 4; end
                    else if (halt_cmd) n_mode = M_HALT;
                    else if (return_cmd) begin n_isr = 1'b0; n_ie = 1'b1; end
                    else if (mem_op) begin if (!mem_ack) n_mode = M_MEMW; end
                    else if (int_valid) begin
                        if (int_op == 2'd0) n_ie = 1'b0;
                        if (int_op == 2'd1) n_ie = 1'b1;
                        if (int_op == 2'd2) sw = 1'b1;
                    end
                end
                M_MEMW: if (mem_ack) n_mode = M_RUN;
                M_ENTRY: begin n_isr = 1'b1; n_ie = 1'b0; n_mode = M_RUN; end
                M_HALT: begin
                    if (take) begin n_epc = pc_in + 16'd2; n_mode = M_ENTRY; end
                    else if (int_valid && int_op == 2'd2) sw = 1'b1;
                end
                default: begin
                    n_ie = 1'b0; n_isr = 1'b0;
                    if (m_rst_left <= 1) n_mode = M_RUN;
                    if (m_rst_left > 0) n_left = m_rst_left - 1;
                end
            endcase
            n_pend = m_pend | ext_irq;
            if (sw) n_pend[0] = 1'b1;
            n_pend = n_pend & ~c.ack;
            if (m_mode == M_SRST) n_pend = 4'h0;
            m_mode <= n_mode; m_int_en <= n_ie; m_in_isr <= n_isr;
            m_pend <= n_pend; m_epc <= n_epc;   m_rst_left <= n_left;
            if (m_mode == M_SRST && m_rst_left > 0) pc_env <= 16'h0;
            else if (c.pc_load) pc_env <= c.plv;
            else if (c.clk_en)  pc_env <= pc_in + 16'd2;
            else                pc_env <= pc_in;
        end
    end

    always @(negedge clk) begin : compare
        comb_t       e;
        logic [26:0] act, exp;
        if (chk_on) begin
            e   = model_comb();
            exp = {e.clk_en, e.mem_req, e.pc_load, (e.pc_load ? e.plv : 16'h0), e.ack,
                   (m_mode == M_SRST && m_rst_left > 0), m_int_en, m_in_isr, (m_mode == M_HALT)};
            act = {clk_en, mem_req, pc_load, (pc_load ? pc_load_value : 16'h0), irq_ack,
                   core_reset, int_enabled, in_isr, halted};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t {clk_en,mem_req,pc_load,plv,ack,core_reset,ie,isr,halted} actual=%h required=%h",
                         $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        halt_cmd = 0; rst_cmd = 0; return_cmd = 0; int_valid = 0; int_op = 2'b11;
        mem_op = 0; mem_ack = 0; ext_irq = 4'h0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        reset = 1'b1; pc_ovr = 1'b0; pc_ovr_val = 16'h0;
        idle();
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_clk_en", 32'(clk_en), 32'd0);
        chk("reset_status", 32'({int_enabled, in_isr, halted, core_reset, mem_req, pc_load}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Plain instructions 0 -> 2 -> 4.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("plain_clk_en", 32'(clk_en), 32'd1);
            chk("plain_quiet", 32'({mem_req, pc_load, irq_ack}), 32'd0);
            nxt();
        end

        // LOAD acked three cycles after the request.
        for (int k = 0; k < 4; k++) begin
            mem_op = 1'b1; mem_ack = (k == 3);
            @(negedge clk);
            chk("load_mem_req", 32'(mem_req), 32'd1);
            chk("load_clk_en", 32'(clk_en), 32'(k == 3));
            nxt();
        end
        @(negedge clk);
        chk("load_done", 32'({mem_req, clk_en}), 32'b01);
        nxt();

        // Enable interrupts, then ext_irq[2] at pc 0x0040.
        int_valid = 1'b1; int_op = 2'b01;
        nxt();
        pc_ovr = 1'b1; pc_ovr_val = 16'h0040; ext_irq = 4'b0100;
        @(negedge clk);
        chk("irq2_int_en", 32'(int_enabled), 32'd1);
        nxt();
        @(negedge clk);
        chk("irq2_take_noexec", 32'(clk_en), 32'd0);
        nxt();
        pc_ovr = 1'b0;
        @(negedge clk);
        chk("irq2_pc_load", 32'(pc_load), 32'd1);
        chk("irq2_vector", 32'(pc_load_value), 32'h0018);
        chk("irq2_ack", 32'(irq_ack), 32'b0100);
        nxt();
        @(negedge clk);
        chk("irq2_isr_state", 32'({in_isr, int_enabled}), 32'b10);
        nxt();
        return_cmd = 1'b1;
        @(negedge clk);
        chk("irq2_ret_value", 32'(pc_load_value), 32'h0040);
        nxt();
        @(negedge clk);
        chk("irq2_ret_int_en", 32'({int_enabled, in_isr}), 32'b10);

        // Two simultaneous requests are served lowest index first.
        ext_irq = 4'b0110;
        nxt(); nxt();
        @(negedge clk);
        chk("dual_first_vector", 32'(pc_load_value), 32'h0014);
        chk("dual_first_ack", 32'(irq_ack), 32'b0010);
        nxt(); nxt();
        return_cmd = 1'b1;
        nxt(); nxt();
        @(negedge clk);
        chk("dual_second_vector", 32'(pc_load_value), 32'h0018);
        chk("dual_second_ack", 32'(irq_ack), 32'b0100);
        nxt();
        return_cmd = 1'b1;
        nxt();

        // HALT at 0x0100, woken by a software trigger.
        pc_ovr = 1'b1; pc_ovr_val = 16'h0100; halt_cmd = 1'b1;
        nxt();
        pc_ovr = 1'b0;
        int_valid = 1'b1; int_op = 2'b10;
        @(negedge clk);
        chk("halt_flags", 32'({halted, clk_en}), 32'b10);
        nxt();
        nxt();
        @(negedge clk);
        chk("halt_wake_vector", 32'(pc_load_value), 32'h0010);
        chk("halt_wake_ack", 32'(irq_ack), 32'b0001);
        nxt();
        return_cmd = 1'b1;
        @(negedge clk);
        chk("halt_ret_value", 32'(pc_load_value), 32'h0102);
        nxt();

        // Soft reset command: four-cycle core_reset pulse.
        rst_cmd = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("srst_core_reset", 32'(core_reset), 32'((k >= 1) && (k <= 4)));
            chk("srst_clk_en", 32'(clk_en), 32'(k == 5));
            if (k == 4) chk("srst_int_en", 32'(int_enabled), 32'd0);
            nxt();
        end

        // Reset while waiting on memory.
        mem_op = 1'b1;
        nxt();
        mem_op = 1'b1; reset = 1'b1;
        nxt();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_memwait_req", 32'(mem_req), 32'd0);
        nxt();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            reset      = ($urandom_range(0, 199) == 0);
            halt_cmd   = ($urandom_range(0, 79) == 0);
            rst_cmd    = ($urandom_range(0, 59) == 0);
            return_cmd = ($urandom_range(0, 15) == 0);
            int_valid  = ($urandom_range(0, 4) == 0);
            int_op     = 2'($urandom_range(0, 3));
            mem_op     = ($urandom_range(0, 4) == 0);
            mem_ack    = ($urandom_range(0, 2) == 0);
            for (int b = 0; b < 4; b++) ext_irq[b] = ($urandom_range(0, 24) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
